// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types and helpers for the bus datapath
package dp_pkg;

    // Bus source codes above the register range, as offsets from NUM_REGS.
    // Codes 0..NUM_REGS-1 select R0..R(NUM_REGS-1) directly.
    typedef enum logic [2:0] {
        SRC_PC   = 3'd0,
        SRC_ZLO  = 3'd1,
        SRC_ZHI  = 3'd2,
        SRC_MDR  = 3'd3,
        SRC_LO   = 3'd4,
        SRC_HI   = 3'd5,
        SRC_NONE = 3'd6
    } src_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2
    } mem_state_e;

    // Width of the encoded bus select: registers plus eight special codes.
    function automatic int src_w(input int num_regs);
        return $clog2(num_regs + 8);
    endfunction

    // Absolute bus_src code of a special source.
    function automatic int src_code(input int num_regs, input src_e s);
        return num_regs + int'(s);
    endfunction

endpackage

// File: rtl/dp_mem_if.sv
// rtl/dp_mem_if.sv - request/acknowledge memory port with timeout
module dp_mem_if
    import dp_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_req,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_mar,
    input  logic [DATA_W-1:0] i_mdr,
    input  logic              i_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_re,
    output logic              o_we,
    output logic              o_mdr_ld,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam int              CNT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;
    logic              r_re;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Transaction FSM: latch address/data on start, wait for ack or timeout.
    // The ack test comes first so an ack in the final counted cycle still completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MEM_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (i_rd_req || i_wr_req) begin
                        r_state <= i_rd_req ? MEM_RD : MEM_WR;
                        r_re    <= i_rd_req;
                        r_we    <= !i_rd_req;
                        r_addr  <= i_mar;
                        r_wdata <= i_mdr;
                        r_cnt   <= '0;
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (i_ack) begin
                        r_done  <= 1'b1;
                        r_state <= MEM_IDLE;
                        r_re    <= 1'b0;
                        r_we    <= 1'b0;
                    end else if (r_cnt == L_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= MEM_IDLE;
                        r_re    <= 1'b0;
                        r_we    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= MEM_IDLE;
                    r_re    <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = (r_state != MEM_IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;
    assign o_re     = r_re;
    assign o_we     = r_we;
    assign o_addr   = r_addr;
    assign o_wdata  = r_wdata;
    assign o_mdr_ld = (r_state == MEM_RD) && i_ack;

endmodule

// File: rtl/dp_bus_datapath.sv
// rtl/dp_bus_datapath.sv - encoded-select shared-bus datapath; LO/HI under DP_HILO_EN
module dp_bus_datapath
    import dp_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          NUM_REGS    = 16,
    parameter int          ADDR_W      = 9,
    parameter int unsigned RESET_PC    = 0,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic                          Clock,
    input  logic                          Clear,
    input  logic [src_w(NUM_REGS)-1:0]    bus_src,
    input  logic                          reg_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]   reg_wr_sel,
    input  logic                          PCin,
    input  logic                          IRin,
    input  logic                          Yin,
    input  logic                          MARin,
    input  logic                          MDRin,
    input  logic                          Zin,
    input  logic                          LOin,
    input  logic                          HIin,
    input  logic                          IncPC,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic                          alu_inc,
    input  logic [2*DATA_W-1:0]           alu_c,
    input  logic                          mem_rd_req,
    input  logic                          mem_wr_req,
    output logic                          mem_busy,
    output logic                          mem_done,
    output logic                          mem_err,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_re,
    output logic                          mem_we,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic [DATA_W-1:0]             bus_out,
    output logic [DATA_W-1:0]             ir_out,
    output logic [DATA_W-1:0]             pc_out
);

    localparam int               SRC_W  = src_w(NUM_REGS);
    localparam int               RSEL_W = $clog2(NUM_REGS);
    localparam logic [SRC_W-1:0] L_NREG = SRC_W'(NUM_REGS);
    localparam logic [SRC_W-1:0] L_PC   = SRC_W'(src_code(NUM_REGS, SRC_PC));
    localparam logic [SRC_W-1:0] L_ZLO  = SRC_W'(src_code(NUM_REGS, SRC_ZLO));
    localparam logic [SRC_W-1:0] L_ZHI  = SRC_W'(src_code(NUM_REGS, SRC_ZHI));
    localparam logic [SRC_W-1:0] L_MDR  = SRC_W'(src_code(NUM_REGS, SRC_MDR));
    localparam logic [SRC_W-1:0] L_LO   = SRC_W'(src_code(NUM_REGS, SRC_LO));
    localparam logic [SRC_W-1:0] L_HI   = SRC_W'(src_code(NUM_REGS, SRC_HI));

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_zlo;
    logic [DATA_W-1:0] r_zhi;
    logic [DATA_W-1:0] r_mdr;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_bus;
    logic              w_mdr_ld;

    // Shared bus driver: R0, NONE and unused codes all read as zero.
    always_comb begin
        w_bus = '0;
        if (bus_src < L_NREG) begin
            if (bus_src != '0) w_bus = r_regs[bus_src[RSEL_W-1:0]];
        end else begin
            case (bus_src)
                L_PC:    w_bus = r_pc;
                L_ZLO:   w_bus = r_zlo;
                L_ZHI:   w_bus = r_zhi;
                L_MDR:   w_bus = r_mdr;
                L_LO:    w_bus = w_lo;
                L_HI:    w_bus = w_hi;
                default: w_bus = '0;
            endcase
        end
    end

    // General register file; R0 is never written so it stays zero.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (reg_wr_en && (reg_wr_sel != '0)) begin
            r_regs[reg_wr_sel] <= w_bus;
        end
    end

    // Special-purpose registers loaded from the bus or the ALU result.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_pc  <= DATA_W'(RESET_PC);
            r_ir  <= '0;
            r_y   <= '0;
            r_zlo <= '0;
            r_zhi <= '0;
            r_mar <= '0;
        end else begin
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (MARin) r_mar <= w_bus[ADDR_W-1:0];
            if (Zin) begin
                r_zlo <= alu_c[DATA_W-1:0];
                r_zhi <= alu_c[2*DATA_W-1:DATA_W];
            end
        end
    end

    // MDR: returning read data has priority over a bus load in the same cycle.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)         r_mdr <= '0;
        else if (w_mdr_ld) r_mdr <= mem_rdata;
        else if (MDRin)    r_mdr <= w_bus;
    end

`ifdef DP_HILO_EN
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;

    // Optional LO/HI pair, loaded from the bus.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            if (LOin) r_lo <= w_bus;
            if (HIin) r_hi <= w_bus;
        end
    end

    assign w_lo = r_lo;
    assign w_hi = r_hi;
`else
    logic w_unused_hilo;
    assign w_unused_hilo = LOin | HIin;
    assign w_lo = '0;
    assign w_hi = '0;
`endif

    dp_mem_if #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_if (
        .i_clk    (Clock),
        .i_rst    (Clear),
        .i_rd_req (mem_rd_req),
        .i_wr_req (mem_wr_req),
        .i_mar    (r_mar),
        .i_mdr    (r_mdr),
        .i_ack    (mem_ack),
        .o_busy   (mem_busy),
        .o_done   (mem_done),
        .o_err    (mem_err),
        .o_re     (mem_re),
        .o_we     (mem_we),
        .o_mdr_ld (w_mdr_ld),
        .o_addr   (mem_addr),
        .o_wdata  (mem_wdata)
    );

    assign alu_a   = IncPC ? DATA_W'(1) : r_y;
    assign alu_b   = w_bus;
    assign alu_inc = IncPC;
    assign bus_out = w_bus;
    assign ir_out  = r_ir;
    assign pc_out  = r_pc;

endmodule

// File: doc/dp_bus_datapath.md
# dp_bus_datapath

Parametrised, encoded-select successor to the one-hot Mini SRC bus datapath. It holds the general register file, PC, IR, Y, Z, HI/LO, MAR and MDR around a single shared bus. It also adds a timed request/acknowledge memory port in place of the direct combinational RAM hookup. The ALU is external: this block drives its operands and captures its 2×DATA_W result into Z.

## Interface
Parameters:
- DATA_W, 32, bus and register width
- NUM_REGS, 16, general registers R0..R(NUM_REGS-1); R0 reads as zero
- ADDR_W, 9, memory address width; MAR[ADDR_W-1:0] is presented
- RESET_PC, 0, PC value on Clear
- MEM_TIMEOUT, 15, cycles to wait for mem_ack before abort (≥1)

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- Clear  in  1  asynchronous, active-high reset
- bus_src  in  SRC_W  encoded bus driver (dp_pkg::src_e; SRC_W=$clog2(NUM_REGS+8))
- reg_wr_en  in  1  write bus into register reg_wr_sel
- reg_wr_sel  in  $clog2(NUM_REGS)  destination register
- PCin, IRin, Yin, MARin, MDRin, Zin, LOin, HIin  in  1 each  load enables
- IncPC  in  1  drive alu_a=1 and alu_inc=1
- alu_a  out  DATA_W  IncPC ? 1 : Y
- alu_b  out  DATA_W  bus value
- alu_inc  out  1  IncPC passthrough (ALU forces ADD)
- alu_c  in  2×DATA_W  ALU result
- mem_rd_req, mem_wr_req  in  1 each  start memory read/write (single-cycle pulse)
- mem_busy  out  1  transaction in flight
- mem_done  out  1  one-cycle pulse on successful completion
- mem_err  out  1  one-cycle pulse on timeout
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_re, mem_we  out  1 each  held until ack or timeout
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion
- bus_out, ir_out, pc_out  out  DATA_W  observation

## Operation
- Bus is combinational on bus_src: R0 → 0; Rn, PC, Zlo, Zhi, MDR, LO, HI → register value; NONE or any unused code → 0.
- Load enables write bus into their register at the edge. Zin writes alu_c[DATA_W-1:0] to Zlo and alu_c[2×DATA_W-1:DATA_W] to Zhi.
- reg_wr_en with reg_wr_sel=0 is ignored.
- Memory FSM states:
  - IDLE: mem_rd_req → RD; mem_wr_req → WR. If both arrive together, read wins and the write is dropped. Entering RD or WR latches mem_addr=MAR[ADDR_W-1:0] and mem_wdata=MDR, and clears the timeout counter.
  - RD/WR: assert mem_re/mem_we. On mem_ack, RD loads MDR←mem_rdata; both pulse mem_done and return to IDLE. When the counter reaches MEM_TIMEOUT with no ack, pulse mem_err, leave MDR unchanged, return to IDLE.
  - Requests while busy are ignored.
  - MARin/MDRin while busy update MAR/MDR but not the latched mem_addr/mem_wdata.
  - If MDRin and a read ack land in the same cycle, the read data wins.
- Clear mid-transaction returns the FSM to IDLE immediately and deasserts mem_re/mem_we.

## Timing
- Reset values: all registers 0 except PC=RESET_PC; mem_busy, mem_done, mem_err, mem_re and mem_we = 0; mem_addr and mem_wdata = 0.
- Register load latency is 1 cycle (new value on the bus the cycle after the enable).
- mem_re/mem_we assert the cycle after the request. An ack in the first asserted cycle gives MDR valid plus a mem_done pulse one cycle later, i.e. 2 cycles from request.
- mem_busy = state≠IDLE.
- An ack arriving in the cycle the counter hits MEM_TIMEOUT completes successfully; ack beats timeout.

## Configuration
- DP_HILO_EN defined: LO/HI registers present, loadable and bus-readable.
- DP_HILO_EN undefined: no LO/HI storage; LOin/HIin ignored; bus_src LO/HI drive 0.

## Structure
- dp_pkg holds:
  - src_e enum (REG base, PC, ZLO, ZHI, MDR, LO, HI, NONE offsets)
  - mem_state_e (IDLE, RD, WR)
  - SRC_W helper function
- Sub-module dp_mem_if contains the FSM, the timeout counter and the address/data latches. It drives the MDR load-from-memory strobe.

## Test plan
- Clear with RESET_PC=0x40 → pc_out=0x40, all others 0, mem_busy=0.
- Load R3=0x12 via MDR→bus, Yin from R3, bus_src=R5(0x34), external ALU add, Zin, bus_src=ZLO → bus_out=0x46.
- Write R0 with 0xFFFF, then bus_src=R0 → bus_out=0.
- MAR=0x1A5, mem_rd_req, ack after 3 cycles with rdata 0xDEADBEEF → mem_addr=0x1A5, MDR=0xDEADBEEF, one mem_done pulse.
- mem_wr_req with no ack, MEM_TIMEOUT=15 → mem_we held 15 cycles, mem_err pulse, MDR unchanged, FSM back to IDLE.
- mem_rd_req and mem_wr_req in the same cycle → only mem_re asserted. Clear mid-read → mem_re drops asynchronously and no mem_done pulse.
